// File: rtl/deck_shuffler.sv
// Card deck builder and shuffler.
// Builds an ordered 52-card deck, optionally shuffles it in place with an
// LFSR-driven Fisher-Yates pass (rejection sampling on j), then deals cards
// one at a time through a valid/ready handshake.
module deck_shuffler (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        shuffle_en_i,
  input  logic [15:0] seed_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        card_valid_o,
  input  logic        card_ready_i,
  output logic [7:0]  card_out_o,
  output logic [5:0]  cards_left_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_INIT    = 2'd1;
  localparam logic [1:0] S_SHUFFLE = 2'd2;
  localparam logic [1:0] S_READY   = 2'd3;

  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
  localparam logic [5:0]  LAST_IDX     = 6'd51;
  localparam logic [5:0]  DECK_SIZE    = 6'd52;

  logic [1:0]  state_q, state_d;
  logic [5:0]  idx_q, idx_d;     // INIT write pointer, then shuffle position i
  logic [1:0]  suit_q, suit_d;   // running idx/13 during INIT
  logic [3:0]  rank_q, rank_d;   // running idx%13+1 during INIT
  logic [15:0] lfsr_q, lfsr_d;
  logic        shuf_q, shuf_d;
  logic [5:0]  top_q, top_d;
  logic [5:0]  left_q, left_d;
  logic        done_q, done_d;

  logic [5:0]  deck [0:51];

  logic [5:0]  j_idx;
  logic        swap;
  logic        lfsr_fb;
  logic        valid;
  logic [5:0]  rd_idx;

  assign j_idx   = lfsr_q[5:0];
  assign swap    = (state_q == S_SHUFFLE) && (j_idx <= idx_q);
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign valid   = (state_q == S_READY) && (left_q != 6'd0);
  // top reaches 52 once the deck is empty; keep the read index in range.
  assign rd_idx  = (top_q < DECK_SIZE) ? top_q : 6'd0;

  assign busy_o       = (state_q == S_INIT) || (state_q == S_SHUFFLE);
  assign done_o       = done_q;
  assign card_valid_o = valid;
  assign card_out_o   = valid ? {2'b00, deck[rd_idx]} : 8'h00;
  assign cards_left_o = left_q;

  // Next-state logic for the controller, LFSR and deal pointers.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    suit_d  = suit_q;
    rank_d  = rank_q;
    lfsr_d  = lfsr_q;
    shuf_d  = shuf_q;
    top_d   = top_q;
    left_d  = left_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_READY: begin
        if (start_i) begin
          // A restart always wins over a pending pop.
          state_d = S_INIT;
          shuf_d  = shuffle_en_i;
          lfsr_d  = (seed_i == 16'd0) ? LFSR_DEFAULT : seed_i;
          idx_d   = 6'd0;
          suit_d  = 2'd0;
          rank_d  = 4'd1;
          top_d   = 6'd0;
          left_d  = 6'd0;
        end else if (valid && card_ready_i) begin
          top_d  = top_q + 6'd1;
          left_d = left_q - 6'd1;
        end
      end
      S_INIT: begin
        idx_d = idx_q + 6'd1;
        if (rank_q == 4'd13) begin
          rank_d = 4'd1;
          suit_d = suit_q + 2'd1;
        end else begin
          rank_d = rank_q + 4'd1;
        end
        if (idx_q == LAST_IDX) begin
          if (shuf_q) begin
            state_d = S_SHUFFLE;
            idx_d   = LAST_IDX;
          end else begin
            state_d = S_READY;
            top_d   = 6'd0;
            left_d  = DECK_SIZE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin // S_SHUFFLE
        lfsr_d = {lfsr_q[14:0], lfsr_fb};
        if (swap) begin
          idx_d = idx_q - 6'd1;
          if (idx_q == 6'd1) begin
            state_d = S_READY;
            top_d   = 6'd0;
            left_d  = DECK_SIZE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  // Control and pointer registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      idx_q   <= 6'd0;
      suit_q  <= 2'd0;
      rank_q  <= 4'd1;
      lfsr_q  <= LFSR_DEFAULT;
      shuf_q  <= 1'b0;
      top_q   <= 6'd0;
      left_q  <= 6'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      suit_q  <= suit_d;
      rank_q  <= rank_d;
      lfsr_q  <= lfsr_d;
      shuf_q  <= shuf_d;
      top_q   <= top_d;
      left_q  <= left_d;
      done_q  <= done_d;
    end
  end

  // Deck storage: sequential fill during INIT, in-place swaps during SHUFFLE.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      if (state_q == S_INIT) begin
        deck[idx_q] <= {suit_q, rank_q};
      end else if (swap) begin
        deck[idx_q] <= deck[j_idx];
        deck[j_idx] <= deck[idx_q];
      end
    end
  end

endmodule
